// File: rtl/alu_arb.sv
// Round-robin arbiter/sequencer for the shared ALU: one op in flight, fixed ALU latency, one-cycle done pulse.
// Latency: grant one edge after request, done ALU_LAT+1 cycles after grant; requesters hold req_i until gnt_o.
package alu_arb_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_AND = 4'd2,
    ALU_OP_OR  = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SLL = 4'd5,
    ALU_OP_SRL = 4'd6,
    ALU_OP_SRA = 4'd7
  } alu_op_t;
endpackage

module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int WORD_LEN = 64,
  parameter int N_REQ    = 2,
  parameter int ALU_LAT  = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [N_REQ*WORD_LEN-1:0]         req_op_a_i,
  input  logic [N_REQ*WORD_LEN-1:0]         req_op_b_i,
  input  logic [N_REQ*$bits(alu_op_t)-1:0]  req_opc_i,
  input  logic                              flush_i,
  input  logic [WORD_LEN-1:0]               alu_op_res_i,
  output logic [WORD_LEN-1:0]               alu_op_a_o,
  output logic [WORD_LEN-1:0]               alu_op_b_o,
  output alu_op_t                           alu_opc_o,
  output logic [N_REQ-1:0]                  gnt_o,
  output logic [N_REQ-1:0]                  done_o,
  output logic [WORD_LEN-1:0]               res_o,
  output logic                              busy_o
);

  localparam int OPW = $bits(alu_op_t);
  localparam int PW  = $clog2(N_REQ);

  if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
    $error("alu_arb: ALU_LAT must be in 1..7");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("alu_arb: N_REQ must be in 2..8");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [WORD_LEN-1:0] res_q, res_d;
  logic [WORD_LEN-1:0] op_a_q, op_a_d;
  logic [WORD_LEN-1:0] op_b_q, op_b_d;
  alu_op_t             opc_q, opc_d;

  logic [WORD_LEN-1:0] op_a_arr [N_REQ];
  logic [WORD_LEN-1:0] op_b_arr [N_REQ];
  alu_op_t             opc_arr  [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign op_a_arr[k] = req_op_a_i[k*WORD_LEN +: WORD_LEN];
    assign op_b_arr[k] = req_op_b_i[k*WORD_LEN +: WORD_LEN];
    assign opc_arr[k]  = alu_op_t'(req_opc_i[k*OPW +: OPW]);
  end

  // Search starts just after the last winner so every requester waits at most N_REQ-1 ops.
  logic          sel_vld;
  logic [PW-1:0] sel_idx;
  logic [PW:0]   cand_sum;
  logic [PW-1:0] cand;

  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand_sum >= (PW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (PW+1)'(N_REQ);
      end
      cand = cand_sum[PW-1:0];
      if (!sel_vld && req_i[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    done_d  = '0;
    res_d   = res_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    opc_d   = opc_q;
    case (state_q)
      IDLE: begin
        if (!flush_i && sel_vld) begin
          op_a_d  = op_a_arr[sel_idx];
          op_b_d  = op_b_arr[sel_idx];
          opc_d   = opc_arr[sel_idx];
          gnt_d   = onehot(sel_idx);
          win_d   = sel_idx;
          cnt_d   = 3'(ALU_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A flushed winner still advances the pointer so it cannot starve the others.
        if (flush_i) begin
          ptr_d   = win_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          res_d   = alu_op_res_i;
          done_d  = onehot(win_q);
          ptr_d   = win_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      opc_q   <= alu_op_t'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      opc_q   <= opc_d;
    end
  end

  assign alu_op_a_o = op_a_q;
  assign alu_op_b_o = op_b_q;
  assign alu_opc_o  = opc_q;
  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign res_o      = res_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/alu_arb.md
# alu_arb

Round-robin arbiter and sequencer for the shared core ALU. Accepts operation requests from up to N_REQ requesters (control unit, future second issue slot, debug unit), grants one at a time, drives the ALU operand and opcode lines, waits a fixed ALU latency and returns the registered result to the winner with a one-cycle done strobe. It sits between the requesters and the ALU, replacing any direct requester-to-ALU operand wiring.

## Interface

Parameters:
- WORD_LEN, 64, operand/result width
- N_REQ, 2, number of requesters (2..8)
- ALU_LAT, 1, cycles from operand change on alu_op_*_o to valid alu_op_res_i (1..7; other values fail elaboration)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock, all state on rising edge
- reset_ni  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester request, level
- req_op_a_i  in  N_REQ*WORD_LEN  operand A, requester k at bits [k*WORD_LEN +: WORD_LEN]
- req_op_b_i  in  N_REQ*WORD_LEN  operand B, same packing
- req_opc_i  in  N_REQ*$bits(alu_op_t)  opcode, same packing
- flush_i  in  1  synchronous abort of the in-flight operation
- alu_op_res_i  in  WORD_LEN  ALU result
- alu_op_a_o  out  WORD_LEN  ALU operand A
- alu_op_b_o  out  WORD_LEN  ALU operand B
- alu_opc_o  out  alu_op_t  ALU opcode
- gnt_o  out  N_REQ  one-hot grant pulse
- done_o  out  N_REQ  one-hot completion pulse
- res_o  out  WORD_LEN  registered result, valid while done_o != 0, held afterwards
- busy_o  out  1  high whenever state != IDLE

## Operation

- States: IDLE, WAIT. Latency counter cnt (3 bits), round-robin pointer ptr (index of last winner), winner index win.
- IDLE, flush_i low, req_i != 0: select first set bit of req_i searching ptr+1, ptr+2, … modulo N_REQ. At the edge: capture winner's operands/opcode into alu_op_a_o/alu_op_b_o/alu_opc_o, gnt_o <= onehot(win), cnt <= ALU_LAT-1, state <= WAIT.
- IDLE, req_i == 0 or flush_i high: stay IDLE, gnt_o <= 0, ALU outputs hold.
- WAIT, flush_i low, cnt != 0: cnt <= cnt-1.
- WAIT, flush_i low, cnt == 0: res_o <= alu_op_res_i, done_o <= onehot(win), ptr <= win, state <= IDLE.
- WAIT, flush_i high: state <= IDLE, no done_o, res_o holds, ptr <= win (aborted winner loses its turn).
- gnt_o and done_o each high for exactly one cycle; all other cycles zero.
- Requester rules: hold req_i and operands stable until gnt_o seen; operands are captured only at grant. req_i still high at the end of the done_o cycle counts as a new request.
- ALU outputs hold their last values outside grant edges; never change in WAIT.
- Reset (async, any state, including mid-WAIT): state IDLE, cnt 0, ptr N_REQ-1 (requester 0 wins first), gnt_o 0, done_o 0, res_o 0, alu_op_a_o 0, alu_op_b_o 0, alu_opc_o alu_op_t'(0), busy_o 0. In-flight operation is discarded, no done_o.

## Timing

- Grant edge t: gnt_o high in cycle t+1; ALU outputs valid from t+1.
- Result sampled at edge t+ALU_LAT; done_o/res_o valid in cycle t+ALU_LAT+1.
- Earliest next grant edge t+ALU_LAT+1; issue interval ALU_LAT+1 cycles, with ALU_LAT=1 one op every 2 cycles.
- Request to grant: one edge from IDLE; a requester waits at most N_REQ-1 other operations.
- flush_i at the sampling edge (cnt == 0) wins: no done_o.
- busy_o registered, rises with gnt_o, falls with done_o (or the cycle after a flush edge).

## Test plan

- Reset then req_i=01, a=5, b=7, opc=ALU_OP_ADD, ALU model returns a+b, ALU_LAT=1 -> gnt_o=01 one cycle later, done_o=01 and res_o=12 one cycle after that, busy_o high exactly 1 cycle.
- req_i=11 held continuously, N_REQ=2 -> grants alternate 01,10,01,10 every 2 cycles; first winner requester 0.
- ALU_LAT=3, single request -> done_o exactly 3 cycles after gnt_o; ALU outputs constant throughout WAIT even if req operands change.
- flush_i asserted in WAIT at cnt==0 -> no done_o, res_o retains previous 12, next grant goes to the other requester.
- reset_ni low mid-WAIT (async, between edges) -> all outputs 0 immediately; after release req_i=10 -> requester 1 granted; no stale done_o.
- flush_i high in IDLE with req_i=01 -> no grant; flush_i low next cycle -> grant 01.
